// File: rtl/encoder83_pending_if.sv
// Request/consumer bundle for the 8-to-3 pending priority encoder.
// The encoder sits on the slave side; the request sources and the code consumer sit on the master side.
interface encoder83_pending_if;
   logic [7:0] Data_in;
   logic [2:0] Data_out;
   logic       Valid_out;
   logic       Ready_in;
   logic [7:0] Pending_out;
   logic       Overrun_out;

   modport master (
      output Data_in,
      output Ready_in,
      input  Data_out,
      input  Valid_out,
      input  Pending_out,
      input  Overrun_out
   );

   modport slave (
      input  Data_in,
      input  Ready_in,
      output Data_out,
      output Valid_out,
      output Pending_out,
      output Overrun_out
   );
endinterface

// File: rtl/encoder83_pending.sv
// 8-to-3 priority encoder with latched requests and a valid/ready output handshake.
// Requests are merged into a pending register; the winning index is retired on its handshake.
module encoder83_pending #(
   parameter bit HIGH_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   encoder83_pending_if.slave  bus
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t     state_q, state_nx;
   logic [7:0] pend_q, pend_nx;
   logic [7:0] clr;
   logic [2:0] code_q, code_nx;
   logic       valid_q, valid_nx;
   logic       ovr_q, ovr_nx;
   logic       hs;

   // Later iterations overwrite earlier ones, so scan from lowest to highest priority.
   function automatic logic [2:0] top_index(input logic [7:0] req);
      logic [2:0] idx;
      top_index = 3'd0;
      for (int k = 0; k < 8; k++) begin
         idx = HIGH_FIRST ? 3'(k) : 3'(7 - k);
         if (req[idx]) top_index = idx;
      end
   endfunction

   assign hs      = valid_q & bus.Ready_in;
   assign clr     = hs ? (8'd1 << code_q) : 8'd0;
   // Set wins: a retiring bit re-asserted in its handshake cycle stays pending.
   assign pend_nx = (pend_q & ~clr) | bus.Data_in;
   assign ovr_nx  = |(bus.Data_in & pend_q & ~clr);

   // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_nx = state_q;
      code_nx  = code_q;
      valid_nx = valid_q;
      unique case (state_q)
         IDLE: begin
            if (pend_nx != 8'd0) begin
               code_nx  = top_index(pend_nx);
               valid_nx = 1'b1;
               state_nx = PRESENT;
            end
         end
         PRESENT: begin
            // No preemption: the presented code only moves on a handshake.
            if (hs) begin
               if (pend_nx != 8'd0) begin
                  code_nx = top_index(pend_nx);
               end else begin
                  valid_nx = 1'b0;
                  state_nx = IDLE;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            valid_nx = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= 8'd0;
         code_q  <= 3'd0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_nx;
         pend_q  <= pend_nx;
         code_q  <= code_nx;
         valid_q <= valid_nx;
         ovr_q   <= ovr_nx;
      end
   end

   assign bus.Data_out    = code_q;
   assign bus.Valid_out   = valid_q;
   assign bus.Pending_out = pend_q;
   assign bus.Overrun_out = ovr_q;

endmodule

// File: tb/tb_encoder83_pending.sv
// Randomized scoreboard bench for encoder83_pending, running both priority orders side by side
// against a set-of-requests reference model.
module tb_encoder83_pending;

   typedef struct packed {
      logic       valid;
      logic [2:0] code;
      logic [7:0] pend;
      logic       ovr;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   encoder83_pending_if bus_h ();
   encoder83_pending_if bus_l ();

   encoder83_pending #(.HIGH_FIRST(1'b1)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h));
   encoder83_pending #(.HIGH_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

   always #5 clk = ~clk;

   exp_t q_h[$];
   exp_t q_l[$];

   // Reference model: set of pending request numbers plus the request currently offered (-1 = none).
   bit   m_pend [2][8];
   int   m_cur  [2];
   int   m_last [2];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input int d, input bit p[8]);
      int i;
      for (int k = 0; k < 8; k++) begin
         i = (d == 0) ? 7 - k : k;
         if (p[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++) m_pend[d][i] = 1'b0;
         m_cur[d]  = -1;
         m_last[d] = 0;
      end
   endtask

   task automatic model_step(input int d, input logic [7:0] din, input logic rdy, output exp_t e);
      bit accepted;
      bit keep;
      bit np[8];
      bit ovr;
      int cnt;
      accepted = (m_cur[d] >= 0) && rdy;
      ovr = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         keep  = m_pend[d][i] && !(accepted && i == m_cur[d]);
         np[i] = keep || din[i];
         if (keep && din[i]) ovr = 1'b1;
      end
      if (m_cur[d] < 0 || accepted) m_cur[d] = pick(d, np);
      if (m_cur[d] >= 0) m_last[d] = m_cur[d];
      e.pend = 8'd0;
      for (int i = 0; i < 8; i++) begin
         m_pend[d][i] = np[i];
         if (np[i]) begin
            e.pend = e.pend + 8'(1 << i);
            cnt++;
         end
      end
      e.valid = (m_cur[d] >= 0);
      e.code  = 3'(m_last[d]);
      e.ovr   = ovr;
   endtask

   // Issue one cycle of stimulus to both DUTs and queue what each should show after the edge.
   task automatic step(input logic [7:0] din, input logic rdy);
      exp_t e;
      bus_h.Data_in  = din;
      bus_h.Ready_in = rdy;
      bus_l.Data_in  = din;
      bus_l.Ready_in = rdy;
      model_step(0, din, rdy, e);
      q_h.push_back(e);
      model_step(1, din, rdy, e);
      q_l.push_back(e);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic compare(input string tag, input exp_t e, input logic v, input logic [2:0] c,
                          input logic [7:0] p, input logic o);
      check({tag, "_valid"},   int'(v), int'(e.valid));
      check({tag, "_code"},    int'(c), int'(e.code));
      check({tag, "_pending"}, int'(p), int'(e.pend));
      check({tag, "_overrun"}, int'(o), int'(e.ovr));
   endtask

   // Monitor: pops the expected response for each edge and compares it with what the DUT shows.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q_h.size() != 0) begin
            e = q_h.pop_front();
            compare("hf1", e, bus_h.Valid_out, bus_h.Data_out, bus_h.Pending_out, bus_h.Overrun_out);
         end
         if (q_l.size() != 0) begin
            e = q_l.pop_front();
            compare("hf0", e, bus_l.Valid_out, bus_l.Data_out, bus_l.Pending_out, bus_l.Overrun_out);
         end
      end
   end

   // Asynchronous reset applied mid-cycle; outputs must clear without waiting for an edge.
   task automatic do_reset();
      rst_n = 1'b0;
      bus_h.Data_in = 8'd0;
      bus_l.Data_in = 8'd0;
      bus_h.Ready_in = 1'b0;
      bus_l.Ready_in = 1'b0;
      #1;
      check("rst_valid_h",   int'(bus_h.Valid_out),   0);
      check("rst_pending_h", int'(bus_h.Pending_out), 0);
      check("rst_code_h",    int'(bus_h.Data_out),    0);
      check("rst_overrun_h", int'(bus_h.Overrun_out), 0);
      check("rst_valid_l",   int'(bus_l.Valid_out),   0);
      check("rst_pending_l", int'(bus_l.Pending_out), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      logic [7:0] din;
      logic       rdy;
      model_reset();
      bus_h.Data_in = 8'd0;
      bus_l.Data_in = 8'd0;
      bus_h.Ready_in = 1'b0;
      bus_l.Ready_in = 1'b0;
      @(negedge clk);
      #1;
      do_reset();
      repeat (3) step(8'h00, 1'b1);

      // Single request, accepted immediately.
      step(8'h20, 1'b1);
      repeat (3) step(8'h00, 1'b1);

      // Priority drain of three requests.
      step(8'h91, 1'b1);
      repeat (4) step(8'h00, 1'b1);

      // Backpressure with a higher-priority arrival: no preemption.
      step(8'h02, 1'b0);
      step(8'h00, 1'b0);
      step(8'h80, 1'b0);
      step(8'h00, 1'b0);
      step(8'h00, 1'b0);
      repeat (4) step(8'h00, 1'b1);

      // Set wins on the handshake edge, then overrun without a handshake.
      step(8'h08, 1'b0);
      step(8'h08, 1'b1);
      step(8'h08, 1'b0);
      step(8'h00, 1'b0);
      repeat (3) step(8'h00, 1'b1);

      // Reset with everything pending and a code on offer.
      step(8'hFF, 1'b0);
      step(8'h00, 1'b0);
      do_reset();
      repeat (3) step(8'h00, 1'b1);

      // Randomized traffic: sparse requests, mixed backpressure.
      for (int n = 0; n < 600; n++) begin
         din = 8'd0;
         for (int b = 0; b < 8; b++) din[b] = ($urandom_range(0, 5) == 0);
         if ((n % 100) > 80) din = 8'd0;
         rdy = ($urandom_range(0, 9) < 6);
         step(din, rdy);
      end
      repeat (12) step(8'h00, 1'b1);

      for (int i = 0; i < 4 && (q_h.size() != 0 || q_l.size() != 0); i++) @(negedge clk);
      check("scoreboard_drained", q_h.size() + q_l.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/encoder83_pending.md
Name: encoder83_pending

Overview:
- Inverse of the team's 3-to-8 one-hot decoder: an 8-to-3 priority encoder with request latching and a valid/ready output handshake.
- Each Data_in bit is a request line. Requests are captured into a pending register, and the highest-priority pending request is presented as a 3-bit binary code.
- The bit is retired when the consumer accepts the code.
- Sits between request sources (one-hot event lines) and any block that consumes the binary index, e.g. one that drives the 3-to-8 decoder back.

Parameters:
- HIGH_FIRST, 1, priority order: 1 = bit 7 highest, bit 0 lowest; 0 = bit 0 highest, bit 7 lowest.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Data_in  input  8  request lines. A bit high in a cycle sets the matching pending bit at that clock edge.
- Data_out  output  3  binary index of the presented request. Meaningful only while Valid_out = 1.
- Valid_out  output  1  Data_out holds a pending request index.
- Ready_in  input  1  consumer accepts; handshake = Valid_out & Ready_in at a rising edge.
- Pending_out  output  8  current pending register, for debug and status.
- Overrun_out  output  1  one-cycle registered pulse: some Data_in bit was asserted while that bit was already pending and not being retired that edge.

Behaviour:
- Reset (async, rst_n = 0): pending = 8'h00, Data_out = 3'b000, Valid_out = 0, Overrun_out = 0, FSM = IDLE. Reset mid-presentation drops all requests; nothing is retained.
- All outputs are registered. No combinational path from Data_in or Ready_in to any output.
- Encoding: bit i maps to code i. 8'b0000_0001 -> 3'd0, 8'b1000_0000 -> 3'd7, matching the decoder mapping.
- Definitions:
  - clr = one-hot of Data_out when handshake, else 0.
  - pend_nx = (pending & ~clr) | Data_in.
- Set/clear rule: set wins. If the retiring bit is re-asserted on Data_in in the handshake cycle, it stays pending.
- FSM states:
  - IDLE (Valid_out = 0): at each edge, if pend_nx != 0, load Data_out with the highest-priority index of pend_nx, set Valid_out = 1, go to PRESENT. Otherwise stay.
  - PRESENT (Valid_out = 1):
    - Without handshake: Data_out and Valid_out hold exactly. A newly arriving higher-priority request does not preempt the presented code.
    - On handshake: if pend_nx != 0, load the next highest-priority index from pend_nx and stay in PRESENT. This allows back-to-back codes, one per cycle, with Valid_out staying 1.
    - On handshake with pend_nx == 0: Valid_out = 0, go to IDLE.
- Latency: a request arriving at edge N with the block idle gives Valid_out = 1 with the code after edge N (visible in cycle N+1).
- Throughput: up to one code per cycle while Ready_in = 1.
- The presented bit stays set in pending until its handshake edge. Pending_out shows it cleared from the following cycle.
- Overrun_out: registered pulse equal to |(Data_in & pending & ~clr). Requests are merged, never counted.
- Ready_in while Valid_out = 0 is ignored.
- Data_out after a drop to IDLE keeps its last value. Consumers must gate on Valid_out.

Test Plan:
1. Reset then idle: rst_n low mid-cycle, Data_in = 0 -> all outputs 0 immediately, Valid_out stays 0 after release.
2. Single request: Data_in = 8'h20 for 1 cycle, Ready_in = 1 -> Valid_out = 1, Data_out = 3'd5 for exactly one cycle, then Valid_out = 0 and Pending_out = 8'h00.
3. Priority drain, HIGH_FIRST = 1: Data_in = 8'h91 one cycle, Ready_in = 1 -> codes 7, 4, 0 on consecutive cycles with Valid_out continuous. With HIGH_FIRST = 0 the order is 0, 4, 7.
4. Backpressure/no preempt: Data_in = 8'h02, Ready_in = 0 for 5 cycles, then Data_in = 8'h80 in cycle 3 -> Data_out stays 3'd1 until Ready_in = 1, then 3'd7 is presented next.
5. Set-wins and overrun: code 3 presented, Ready_in = 1 and Data_in = 8'h08 the same cycle -> Data_out = 3 again next cycle, no overrun pulse. Data_in = 8'h08 while 3 is pending without handshake -> Overrun_out = 1 for one cycle.
6. Reset mid-operation: pending = 8'hFF, Valid_out = 1, rst_n pulsed low -> Pending_out = 8'h00, Valid_out = 0 asynchronously, no codes emitted after release until new requests arrive.
